// File: rtl/aqms_pkg.sv
// Shared types for the CPU I/O bridge: FSM states, decode classes and the
// addr[7:6] port-range codes for the VDP and counter/PSG windows.
package aqms_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_SEL  = 2'd2,
    ST_RD_HOLD = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_VDP  = 2'd1,
    CLS_CNT  = 2'd2,
    CLS_PSG  = 2'd3
  } cls_e;

  localparam logic [1:0] RANGE_CNT_PSG = 2'b01;
  localparam logic [1:0] RANGE_VDP     = 2'b10;

  // The 0x40-0x7F window is the counters on reads and the PSG on writes.
  function automatic cls_e decode_class(input logic [1:0] addr_hi, input logic is_write);
    cls_e cls;
    case (addr_hi)
      RANGE_VDP:     cls = CLS_VDP;
      RANGE_CNT_PSG: cls = is_write ? CLS_PSG : CLS_CNT;
      default:       cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/vdp_io_bridge.sv
// Z80 I/O cycle decoder driving the VDP register-port handshake, the PSG
// write strobe and the registered CPU read-back byte.
module vdp_io_bridge
  import aqms_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] cpu_addr,
  input  logic       cpu_iorq_n,
  input  logic       cpu_rd_n,
  input  logic       cpu_wr_n,
  input  logic [7:0] cpu_wrdata,
  output logic [7:0] cpu_rddata,
  output logic       cpu_rddata_oe,
  output logic       io_portsel,
  output logic [7:0] io_wrdata,
  output logic       io_wren,
  output logic       io_wrdone,
  output logic       io_rddone,
  input  logic [7:0] io_rddata,
  input  logic [7:0] vcnt,
  input  logic [7:0] hcnt,
  output logic       psg_wren,
  output logic [7:0] psg_wrdata
);

  state_e     state_q, state_d;
  cls_e       cls_q, cls_d;
  logic       a0_q, a0_d;
  logic       io_portsel_q, io_portsel_d;
  logic [7:0] io_wrdata_q, io_wrdata_d;
  logic [7:0] psg_wrdata_q, psg_wrdata_d;
  logic [7:0] cpu_rddata_q, cpu_rddata_d;
  logic       oe_q, oe_d;
  logic       io_wren_q, io_wren_d;
  logic       io_wrdone_q, io_wrdone_d;
  logic       io_rddone_q, io_rddone_d;
  logic       psg_wren_q, psg_wren_d;

  logic       wr_req_s, rd_req_s, wr_rel_s, rd_rel_s;
  cls_e       cls_det_s;
  logic       unused_addr_s;

  assign wr_req_s  = !cpu_iorq_n && !cpu_wr_n && cpu_rd_n;
  assign rd_req_s  = !cpu_iorq_n && !cpu_rd_n && cpu_wr_n;
  assign wr_rel_s  = cpu_iorq_n || cpu_wr_n;
  assign rd_rel_s  = cpu_iorq_n || cpu_rd_n;
  assign cls_det_s = decode_class(cpu_addr[7:6], wr_req_s);
  assign unused_addr_s = ^cpu_addr[5:1];

  // Next-state, decode latching and pulse generation.
  always_comb begin
    state_d      = state_q;
    cls_d        = cls_q;
    a0_d         = a0_q;
    io_portsel_d = io_portsel_q;
    io_wrdata_d  = io_wrdata_q;
    psg_wrdata_d = psg_wrdata_q;
    cpu_rddata_d = cpu_rddata_q;
    oe_d         = oe_q;
    io_wren_d    = 1'b0;
    io_wrdone_d  = 1'b0;
    io_rddone_d  = 1'b0;
    psg_wren_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wr_req_s || rd_req_s) begin
          state_d = wr_req_s ? ST_WR : ST_RD_SEL;
          cls_d   = cls_det_s;
          a0_d    = cpu_addr[0];
          case (cls_det_s)
            CLS_VDP: begin
              io_portsel_d = cpu_addr[0];
              if (wr_req_s) begin
                io_wrdata_d = cpu_wrdata;
                io_wren_d   = 1'b1;
              end else begin
                oe_d = 1'b1;
              end
            end
            CLS_PSG: begin
              psg_wrdata_d = cpu_wrdata;
              psg_wren_d   = 1'b1;
            end
            CLS_CNT: oe_d = 1'b1;
            default: ;
          endcase
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WR: begin
        if (wr_rel_s) begin
          state_d     = ST_IDLE;
          io_wrdone_d = (cls_q == CLS_VDP);
        end else begin
          state_d = ST_WR;
        end
      end
      ST_RD_SEL: begin
        // Capture happens even if the CPU already let go; RD_HOLD then exits.
        state_d = ST_RD_HOLD;
        case (cls_q)
          CLS_VDP: cpu_rddata_d = io_rddata;
          CLS_CNT: cpu_rddata_d = a0_q ? hcnt : vcnt;
          default: ;
        endcase
      end
      ST_RD_HOLD: begin
        if (rd_rel_s) begin
          state_d     = ST_IDLE;
          oe_d        = 1'b0;
          io_rddone_d = (cls_q == CLS_VDP);
        end else begin
          state_d = ST_RD_HOLD;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      cls_q        <= CLS_NONE;
      a0_q         <= 1'b0;
      io_portsel_q <= 1'b0;
      io_wrdata_q  <= 8'h00;
      psg_wrdata_q <= 8'h00;
      cpu_rddata_q <= 8'h00;
      oe_q         <= 1'b0;
      io_wren_q    <= 1'b0;
      io_wrdone_q  <= 1'b0;
      io_rddone_q  <= 1'b0;
      psg_wren_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cls_q        <= cls_d;
      a0_q         <= a0_d;
      io_portsel_q <= io_portsel_d;
      io_wrdata_q  <= io_wrdata_d;
      psg_wrdata_q <= psg_wrdata_d;
      cpu_rddata_q <= cpu_rddata_d;
      oe_q         <= oe_d;
      io_wren_q    <= io_wren_d;
      io_wrdone_q  <= io_wrdone_d;
      io_rddone_q  <= io_rddone_d;
      psg_wren_q   <= psg_wren_d;
    end
  end

  assign cpu_rddata    = cpu_rddata_q;
  assign cpu_rddata_oe = oe_q;
  assign io_portsel    = io_portsel_q;
  assign io_wrdata     = io_wrdata_q;
  assign io_wren       = io_wren_q;
  assign io_wrdone     = io_wrdone_q;
  assign io_rddone     = io_rddone_q;
  assign psg_wren      = psg_wren_q;
  assign psg_wrdata    = psg_wrdata_q;

endmodule

// File: tb/tb_vdp_io_bridge.sv
// Directed bench for vdp_io_bridge: expectations are queued as each bus cycle
// is driven and popped against the DUT when the response is due.
module tb_vdp_io_bridge;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [7:0] cpu_addr;
  logic       cpu_iorq_n, cpu_rd_n, cpu_wr_n;
  logic [7:0] cpu_wrdata;
  logic [7:0] cpu_rddata;
  logic       cpu_rddata_oe;
  logic       io_portsel;
  logic [7:0] io_wrdata;
  logic       io_wren, io_wrdone, io_rddone;
  logic [7:0] io_rddata, vcnt, hcnt;
  logic       psg_wren;
  logic [7:0] psg_wrdata;

  vdp_io_bridge dut (
    .clk(clk), .reset_n(reset_n),
    .cpu_addr(cpu_addr), .cpu_iorq_n(cpu_iorq_n), .cpu_rd_n(cpu_rd_n), .cpu_wr_n(cpu_wr_n),
    .cpu_wrdata(cpu_wrdata), .cpu_rddata(cpu_rddata), .cpu_rddata_oe(cpu_rddata_oe),
    .io_portsel(io_portsel), .io_wrdata(io_wrdata), .io_wren(io_wren),
    .io_wrdone(io_wrdone), .io_rddone(io_rddone), .io_rddata(io_rddata),
    .vcnt(vcnt), .hcnt(hcnt), .psg_wren(psg_wren), .psg_wrdata(psg_wrdata)
  );

  always #5 clk = ~clk;

  // Pulse / enable activity counters, sampled on the inactive edge.
  int n_wren = 0, n_wrdone = 0, n_rddone = 0, n_psg = 0, n_oe = 0;
  always @(negedge clk) begin
    if (io_wren)       n_wren++;
    if (io_wrdone)     n_wrdone++;
    if (io_rddone)     n_rddone++;
    if (psg_wren)      n_psg++;
    if (cpu_rddata_oe) n_oe++;
  end

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int b_wren, b_wrdone, b_rddone, b_psg, b_oe;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic pop_check(input logic [31:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $error("FAIL sb_empty observed=%0h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic snap();
    b_wren = n_wren; b_wrdone = n_wrdone; b_rddone = n_rddone; b_psg = n_psg; b_oe = n_oe;
  endtask

  task automatic start_wr(input logic [7:0] addr, input logic [7:0] data);
    cpu_addr = addr; cpu_wrdata = data; cpu_iorq_n = 1'b0; cpu_wr_n = 1'b0;
  endtask

  task automatic start_rd(input logic [7:0] addr);
    cpu_addr = addr; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0;
  endtask

  task automatic release_bus();
    cpu_iorq_n = 1'b1; cpu_rd_n = 1'b1; cpu_wr_n = 1'b1;
  endtask

  task automatic check_reset_values(input string pfx);
    push({pfx, "_portsel"}, 32'd0);    pop_check({31'd0, io_portsel});
    push({pfx, "_wrdata"}, 32'h00);    pop_check({24'd0, io_wrdata});
    push({pfx, "_psgdata"}, 32'h00);   pop_check({24'd0, psg_wrdata});
    push({pfx, "_rddata"}, 32'h00);    pop_check({24'd0, cpu_rddata});
    push({pfx, "_oe"}, 32'd0);         pop_check({31'd0, cpu_rddata_oe});
    push({pfx, "_pulses"}, 32'd0);
    pop_check({28'd0, io_wren, io_wrdone, io_rddone, psg_wren});
  endtask

  initial begin
    reset_n = 1'b1;
    cpu_addr = 8'h00; cpu_wrdata = 8'h00; release_bus();
    io_rddata = 8'h00; vcnt = 8'h00; hcnt = 8'h00;
    #1 reset_n = 1'b0;
    repeat (2) tick();
    check_reset_values("rst");
    reset_n = 1'b1;
    repeat (2) tick();

    // VDP control write OUT (0xBF),0x40 held 4 clocks, address/data disturbed mid-cycle
    snap();
    start_wr(8'hBF, 8'h40);
    push("vwr_wren", 32'd1); push("vwr_portsel", 32'd1); push("vwr_wrdata", 32'h40);
    tick();
    pop_check({31'd0, io_wren}); pop_check({31'd0, io_portsel}); pop_check({24'd0, io_wrdata});
    cpu_addr = 8'h00; cpu_wrdata = 8'hFF;
    push("vwr_wren_one_clk", 32'd0);
    tick();
    pop_check({31'd0, io_wren});
    repeat (2) tick();
    release_bus();
    push("vwr_no_early_done", 32'd0); pop_check({31'd0, io_wrdone});
    push("vwr_wrdone", 32'd1); push("vwr_wrdata_held", 32'h40);
    tick();
    pop_check({31'd0, io_wrdone}); pop_check({24'd0, io_wrdata});
    tick();
    push("vwr_wren_count", 32'd1);   pop_check(n_wren - b_wren);
    push("vwr_wrdone_count", 32'd1); pop_check(n_wrdone - b_wrdone);

    // VDP data read IN (0xBE); VDP data changes after capture
    snap();
    io_rddata = 8'hA5;
    start_rd(8'hBE);
    push("vrd_oe", 32'd1); push("vrd_portsel", 32'd0);
    tick();
    pop_check({31'd0, cpu_rddata_oe}); pop_check({31'd0, io_portsel});
    push("vrd_capture", 32'hA5);
    tick();
    pop_check({24'd0, cpu_rddata});
    io_rddata = 8'h5A;
    push("vrd_frozen", 32'hA5); push("vrd_oe_hold", 32'd1);
    tick();
    pop_check({24'd0, cpu_rddata}); pop_check({31'd0, cpu_rddata_oe});
    tick();
    release_bus();
    push("vrd_no_early_done", 32'd0); pop_check({31'd0, io_rddone});
    push("vrd_rddone", 32'd1);
    tick();
    pop_check({31'd0, io_rddone});
    tick();
    push("vrd_oe_off", 32'd0);       pop_check({31'd0, cpu_rddata_oe});
    push("vrd_rddone_count", 32'd1); pop_check(n_rddone - b_rddone);

    // Counter reads IN (0x7E) / IN (0x7F)
    snap();
    vcnt = 8'hC3; hcnt = 8'h21;
    start_rd(8'h7E);
    push("cnt_v", 32'hC3); push("cnt_v_oe", 32'd1);
    repeat (2) tick();
    pop_check({24'd0, cpu_rddata}); pop_check({31'd0, cpu_rddata_oe});
    release_bus();
    repeat (2) tick();
    start_rd(8'h7F);
    push("cnt_h", 32'h21);
    repeat (2) tick();
    pop_check({24'd0, cpu_rddata});
    release_bus();
    repeat (2) tick();
    push("cnt_no_rddone", 32'd0); pop_check(n_rddone - b_rddone);

    // PSG write OUT (0x7F),0x9F
    snap();
    start_wr(8'h7F, 8'h9F);
    push("psg_wren", 32'd1); push("psg_wrdata", 32'h9F); push("psg_no_io_wren", 32'd0);
    tick();
    pop_check({31'd0, psg_wren}); pop_check({24'd0, psg_wrdata}); pop_check({31'd0, io_wren});
    tick();
    release_bus();
    repeat (2) tick();
    push("psg_count", 32'd1);        pop_check(n_psg - b_psg);
    push("psg_no_vdp_pulses", 32'd0);
    pop_check((n_wren - b_wren) + (n_wrdone - b_wrdone));
    push("psg_io_wrdata_kept", 32'h40); pop_check({24'd0, io_wrdata});

    // Unmapped OUT (0x10)
    snap();
    start_wr(8'h10, 8'h55);
    repeat (3) tick();
    release_bus();
    repeat (2) tick();
    push("none_no_activity", 32'd0);
    pop_check((n_wren - b_wren) + (n_wrdone - b_wrdone) + (n_rddone - b_rddone)
              + (n_psg - b_psg) + (n_oe - b_oe));
    push("none_psgdata_kept", 32'h9F); pop_check({24'd0, psg_wrdata});

    // Both strobes low on a VDP port
    snap();
    cpu_addr = 8'hBF; cpu_iorq_n = 1'b0; cpu_rd_n = 1'b0; cpu_wr_n = 1'b0;
    repeat (3) tick();
    release_bus();
    repeat (2) tick();
    push("both_no_detect", 32'd0);
    pop_check((n_wren - b_wren) + (n_wrdone - b_wrdone) + (n_rddone - b_rddone)
              + (n_psg - b_psg) + (n_oe - b_oe));

    // One-clock read on 0xBF: release lands in RD_SEL
    snap();
    io_rddata = 8'h3C;
    start_rd(8'hBF);
    tick();
    release_bus();
    push("short_capture", 32'h3C); push("short_portsel", 32'd1);
    tick();
    pop_check({24'd0, cpu_rddata}); pop_check({31'd0, io_portsel});
    push("short_rddone", 32'd1);
    tick();
    pop_check({31'd0, io_rddone});
    repeat (2) tick();
    push("short_rddone_count", 32'd1); pop_check(n_rddone - b_rddone);

    // Reset while a VDP write is in WR, strobe held through reset release
    start_wr(8'hBF, 8'h77);
    repeat (2) tick();
    reset_n = 1'b0;
    #1;
    snap();
    check_reset_values("midrst");
    tick();
    reset_n = 1'b1;
    push("rst_fresh_wren", 32'd1); push("rst_fresh_wrdata", 32'h77);
    push("rst_no_abort_done", 32'd0);
    tick();
    pop_check({31'd0, io_wren}); pop_check({24'd0, io_wrdata});
    pop_check(n_wrdone - b_wrdone);
    release_bus();
    repeat (3) tick();
    push("rst_fresh_done_count", 32'd1); pop_check(n_wrdone - b_wrdone);

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vdp_io_bridge.md
# vdp_io_bridge

CPU-side initiator for the VDP register port interface. It decodes synchronised Z80 I/O cycles and turns them into the VDP's `io_portsel`/`io_wren`/`io_wrdone`/`io_rddone` handshake. It also returns VDP data, status and counter bytes to the CPU data bus, and emits a write strobe for the PSG port range. It sits between the CPU bus front-end and the `video` block in the `clk` domain.

## Interface
- No parameters. The port map is fixed: the VDP occupies 0x80–0xBF and the counters/PSG occupy 0x40–0x7F.
- Reset: one clock; reset is asynchronous and active-low. The ports are `clk` and `reset_n`.
- `clk` in 1: system clock, the same clock as the VDP register interface.
- `reset_n` in 1: asynchronous active-low reset.
- `cpu_addr` in 8: I/O port address, already synchronised to `clk`.
- `cpu_iorq_n` in 1: I/O request, synchronised, active-low.
- `cpu_rd_n` in 1: read strobe, synchronised, active-low.
- `cpu_wr_n` in 1: write strobe, synchronised, active-low.
- `cpu_wrdata` in 8: CPU write data.
- `cpu_rddata` out 8: registered byte returned to the CPU.
- `cpu_rddata_oe` out 1: the bridge owns the CPU data bus for the current read.
- `io_portsel` out 1: 0 selects data, 1 selects control. It is held for the whole cycle.
- `io_wrdata` out 8: latched write byte.
- `io_wren` out 1: one-cycle pulse at the start of a VDP write.
- `io_wrdone` out 1: one-cycle pulse at the end of a VDP write.
- `io_rddone` out 1: one-cycle pulse at the end of a VDP read.
- `io_rddata` in 8: combinational VDP read data, selected by `io_portsel`.
- `vcnt` in 8: VDP V counter.
- `hcnt` in 8: VDP H counter.
- `psg_wren` out 1: one-cycle pulse for writes to 0x40–0x7F.
- `psg_wrdata` out 8: latched PSG byte.

## Operation
- A cycle is detected when the state is IDLE and `!cpu_iorq_n` holds together with exactly one of `!cpu_rd_n` or `!cpu_wr_n`.
- If both strobes are low, nothing is detected and the state stays IDLE.
- Decode class comes from `cpu_addr[7:6]` and is latched at detection together with `cpu_addr[0]` and `cpu_wrdata`:
  - 01 = CNT/PSG
  - 10 = VDP
  - 00 and 11 = NONE
- A NONE cycle produces no outputs, but the FSM still tracks it until release.
- States:
  - IDLE
  - WR (write active)
  - RD_SEL (port select settling)
  - RD_HOLD (read data held)
- Transitions:
  - IDLE→WR on write detect.
  - IDLE→RD_SEL on read detect.
  - RD_SEL→RD_HOLD unconditionally.
  - WR and RD_HOLD go to IDLE on release: `cpu_iorq_n` high or the active strobe high.
- VDP write:
  - `io_portsel` and `io_wrdata` are registered at detection.
  - `io_wren` pulses in the first WR cycle.
  - `io_wrdone` pulses in the cycle after release is seen.
- PSG write: `psg_wren` pulses in the first WR cycle with `psg_wrdata` latched. There is no done pulse.
- VDP read:
  - `io_portsel` is valid from the RD_SEL cycle.
  - `cpu_rddata` captures `io_rddata` at the end of RD_SEL and holds it through RD_HOLD, so the status byte is frozen for the CPU.
  - `io_rddone` pulses in the cycle after release.
- Counter read:
  - `cpu_rddata` captures `vcnt` if `cpu_addr[0]`=0, otherwise `hcnt`, at the end of RD_SEL.
  - No `io_rddone` pulse is generated.
- `cpu_rddata_oe` is high from RD_SEL through the release cycle for VDP and CNT reads only. It is never high for NONE.
- Address or data changes mid-cycle are ignored, because all decode is latched.

## Timing
- Reset values:
  - All pulse outputs = 0.
  - `io_portsel` = 0.
  - `io_wrdata`, `psg_wrdata`, `cpu_rddata` = 0x00.
  - `cpu_rddata_oe` = 0.
  - State = IDLE.
- Write latency: `io_wren` is asserted 1 clk after the detect edge, i.e. registered.
- Read latency: `cpu_rddata` is valid 2 clk after detect.
- Done pulses are 1 clk wide and occur exactly once per cycle.
- A release seen during RD_SEL is deferred: capture still completes, then RD_HOLD sees the release immediately and pulses `io_rddone` one cycle later.
- Back-to-back cycles:
  - A new detect is accepted only from IDLE.
  - There is a minimum of 1 IDLE clk between cycles, which the done-pulse cycle provides.
- Reset mid-cycle:
  - All outputs are forced to reset values.
  - No done pulse is ever emitted for the aborted cycle.
  - After reset release, a still-asserted strobe is treated as a new cycle.

## Structure
- The shared package `aqms_pkg` holds:
  - the state enum;
  - the decode-class enum (NONE, VDP, CNT, PSG);
  - the port-range constants 2'b01/2'b10 for `addr[7:6]`.
- The design is a single module. No sub-module is warranted.

## Test plan
- **VDP control write:** OUT (0xBF),0x40, held 4 clk.
  - Expect `io_portsel`=1, `io_wrdata`=0x40 and `io_wren` high for 1 clk, 1 clk after detect.
  - Expect `io_wrdone` high 1 clk after release.
- **VDP data read:** IN (0xBE) with the model driving `io_rddata`=0xA5, then changing to 0x5A mid-cycle.
  - Expect `cpu_rddata`=0xA5 held with `cpu_rddata_oe`=1.
  - Expect exactly one `io_rddone` after release.
- **Counter read:** IN (0x7E) and IN (0x7F) with `vcnt`=0xC3 and `hcnt`=0x21.
  - Expect `cpu_rddata`=0xC3, then 0x21.
  - Expect no `io_rddone`.
- **PSG write:** OUT (0x7F),0x9F.
  - Expect `psg_wren` 1 clk with `psg_wrdata`=0x9F.
  - Expect no `io_wren` or `io_wrdone`.
- **Unmapped and malformed cycles:**
  - OUT (0x10) produces no outputs.
  - Both `cpu_rd_n` and `cpu_wr_n` low produces no detection.
  - A 1-clk read on 0xBF still yields a captured status byte and one `io_rddone`.
- **Reset during a write:** assert `reset_n`=0 in WR.
  - Expect all outputs at reset values and no `io_wrdone`.
  - Hold the strobe through reset release; expect a fresh `io_wren`.
